// File: rtl/tdc_readout_serializer.sv
// Readout serializer: captures the event count when the measurement window closes
// and shifts it MSB-first over a frame/sclk/sdata link, flagging dropped results.
module tdc_readout_serializer #(
    parameter int unsigned COUNTER_BITS = 8,
    parameter int unsigned BIT_CYCLES   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    running,
    input  logic [COUNTER_BITS-1:0] count_in,
    input  logic                    clr_overrun,
    output logic                    frame_out,
    output logic                    sclk_out,
    output logic                    sdata_out,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);

    localparam int unsigned BIT_W = $clog2(COUNTER_BITS);
    localparam int unsigned CYC_W = $clog2(BIT_CYCLES);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(COUNTER_BITS - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(BIT_CYCLES / 2);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t                  state_q, state_d;
    logic                    running_q;
    logic [COUNTER_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;
    logic                    overrun_q, overrun_d;
    logic                    fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            shift_q   <= '0;
            bit_q     <= '0;
            cyc_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            cyc_q     <= cyc_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        fall      = running_q & ~running;
        state_d   = state_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        cyc_d     = cyc_q;
        overrun_d = clr_overrun ? 1'b0 : overrun_q;
        frame_out = 1'b0;
        sclk_out  = 1'b0;
        sdata_out = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    shift_d = count_in;
                    bit_d   = '0;
                    cyc_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                frame_out = 1'b1;
                busy      = 1'b1;
                sdata_out = shift_q[COUNTER_BITS-1];
                sclk_out  = (cyc_q >= CYC_HALF);
                // A new result during readout is dropped; setting beats a same-cycle clear.
                if (fall) overrun_d = 1'b1;
                if (cyc_q == CYC_LAST) begin
                    cyc_d   = '0;
                    shift_d = {shift_q[COUNTER_BITS-2:0], 1'b0};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) state_d = DONE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            DONE: begin
                done = 1'b1;
                if (fall) begin
                    shift_d = count_in;
                    bit_d   = '0;
                    cyc_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign overrun = overrun_q;

endmodule

// File: tb/tb_tdc_readout_serializer.sv
// Self-checking bench for tdc_readout_serializer (8-bit frames, 4 clk per bit),
// compared cycle by cycle against a frame-position reference model.
module tb_tdc_readout_serializer;

    localparam int NB    = 8;
    localparam int BC    = 4;
    localparam int FRAME = NB * BC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          running = 1'b0;
    logic [NB-1:0] count_in = '0;
    logic          clr_overrun = 1'b0;
    logic          frame_out, sclk_out, sdata_out, busy, done, overrun;
    logic [5:0]    obs;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    tdc_readout_serializer #(.COUNTER_BITS(NB), .BIT_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .running(running), .count_in(count_in),
        .clr_overrun(clr_overrun), .frame_out(frame_out), .sclk_out(sclk_out),
        .sdata_out(sdata_out), .busy(busy), .done(done), .overrun(overrun)
    );

    assign obs = {frame_out, sclk_out, sdata_out, busy, done, overrun};

    // Reference model: m_pos is the position inside the current frame (-1 = no frame).
    int            m_pos  = -1;
    logic [NB-1:0] m_data = '0;
    bit            m_done = 1'b0;
    bit            m_ovr  = 1'b0;
    bit            m_prev = 1'b0;

    always @(posedge clk) begin : model_b
        bit fall;
        fall = m_prev && !running;
        if (rst) begin
            m_pos = -1; m_done = 1'b0; m_ovr = 1'b0; m_prev = 1'b0;
        end else begin
            if (clr_overrun) m_ovr = 1'b0;
            if (m_pos >= 0) begin
                if (fall) m_ovr = 1'b1;
                m_pos  = m_pos + 1;
                m_done = (m_pos == FRAME);
                if (m_done) m_pos = -1;
            end else begin
                m_done = 1'b0;
                if (fall) begin m_pos = 0; m_data = count_in; end
            end
            m_prev = running;
        end
    end

    function automatic logic [5:0] exp_vec();
        logic fr, sc, sd;
        fr = (m_pos >= 0);
        sc = 1'b0;
        sd = 1'b0;
        if (fr) begin
            sc = ((m_pos % BC) >= BC / 2);
            sd = m_data[NB - 1 - m_pos / BC];
        end
        return {fr, sc, sd, fr, m_done, m_ovr};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== 6'b0 || obs !== exp_vec()) begin
                errors++; $display("FAIL reset cyc %0d: got %b want %b", i, obs, exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_frame(input logic [NB-1:0] val, input string name);
        int frames = 0, rises = 0, first = -1, done_at = -1;
        logic prev_sclk = 1'b0;
        count_in = val;
        running  = 1'b1;
        repeat (2) @(negedge clk);
        running = 1'b0;
        for (int i = 0; i < FRAME + 4; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL %s cyc %0d: got %b want %b", name, i, obs, exp_vec());
            end
            if (frame_out === 1'b1) begin frames++; if (first < 0) first = i; end
            if (done === 1'b1 && done_at < 0) done_at = i;
            if (sclk_out === 1'b1 && prev_sclk === 1'b0) rises++;
            prev_sclk = sclk_out;
        end
        vectors++;
        if (frames != FRAME || first != 0 || done_at != FRAME || rises != NB || overrun !== 1'b0) begin
            errors++;
            $display("FAIL %s shape: frames %0d first %0d done %0d rises %0d ovr %b want %0d 0 %0d %0d 0",
                     name, frames, first, done_at, rises, overrun, FRAME, FRAME, NB);
        end
    endtask

    task automatic test_overrun();
        int frames = 0;
        count_in = 8'($urandom);
        running  = 1'b1;
        repeat (2) @(negedge clk);
        running = 1'b0;
        for (int i = 0; i < FRAME + 8; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL overrun cyc %0d: got %b want %b", i, obs, exp_vec());
            end
            if (frame_out === 1'b1) frames++;
            if (i == 8) begin running = 1'b1; count_in = ~count_in; end
            if (i == 9) running = 1'b0;
            if (i == 10) begin
                vectors++;
                if (overrun !== 1'b1) begin
                    errors++; $display("FAIL overrun_set: got %b want 1", overrun);
                end
            end
        end
        vectors++;
        if (frames != FRAME) begin
            errors++; $display("FAIL overrun_frames: got %0d want %0d", frames, FRAME);
        end
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        @(negedge clk);
        vectors++;
        if (overrun !== 1'b0 || obs !== exp_vec()) begin
            errors++; $display("FAIL overrun_clear: got %b want %b", obs, exp_vec());
        end
    endtask

    task automatic test_reset_midframe();
        int dones = 0;
        count_in = 8'($urandom);
        running  = 1'b1;
        repeat (2) @(negedge clk);
        running = 1'b0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_vec() || (i == 15 && obs !== 6'b0)) begin
                errors++; $display("FAIL rst_mid cyc %0d: got %b want %b", i, obs, exp_vec());
            end
            if (done === 1'b1) dones++;
            if (i == 14) rst = 1'b1;
            if (i == 15) rst = 1'b0;
        end
        vectors++;
        if (dones != 0) begin
            errors++; $display("FAIL rst_mid_done: got %0d pulses want 0", dones);
        end
        test_frame(8'($urandom), "after_rst");
    endtask

    task automatic test_back_to_back();
        int frames = 0, dones = 0, restart = -1;
        bit relaunched = 1'b0;
        count_in = 8'($urandom);
        running  = 1'b1;
        repeat (2) @(negedge clk);
        running = 1'b0;
        for (int i = 0; i < 2 * FRAME + 8; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL b2b cyc %0d: got %b want %b", i, obs, exp_vec());
            end
            if (frame_out === 1'b1) frames++;
            if (relaunched && restart < 0 && frame_out === 1'b1) restart = i;
            if (i == 20) running = 1'b1;
            if (done === 1'b1) begin
                dones++;
                if (!relaunched) begin
                    relaunched = 1'b1; count_in = 8'($urandom); running = 1'b0;
                end
            end
        end
        vectors++;
        if (frames != 2 * FRAME || dones != 2 || restart != FRAME + 1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b shape: frames %0d dones %0d restart %0d ovr %b want %0d 2 %0d 0",
                     frames, dones, restart, overrun, 2 * FRAME, FRAME + 1);
        end
    endtask

    task automatic test_rise_only();
        int busy_cycles = 0;
        running = 1'b0;
        repeat (2) @(negedge clk);
        running = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL rise_only cyc %0d: got %b want %b", i, obs, exp_vec());
            end
            if (busy !== 1'b0) busy_cycles++;
        end
        vectors++;
        if (busy_cycles != 0) begin
            errors++; $display("FAIL rise_only_busy: got %0d busy cycles want 0", busy_cycles);
        end
        running = 1'b0;
        @(negedge clk);
        running = 1'b1;
        repeat (FRAME + 4) @(negedge clk);
        running = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random cyc %0d: got %b want %b", i, obs, exp_vec());
            end
            if ($urandom_range(0, 11) == 0) running = ~running;
            clr_overrun = ($urandom_range(0, 23) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            count_in    = 8'($urandom);
        end
        rst = 1'b0;
        clr_overrun = 1'b0;
        running = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5, "frame_a5");
        test_frame(8'h00, "frame_00");
        test_frame(8'hFF, "frame_ff");
        test_frame(8'($urandom), "frame_rand");
        test_overrun();
        test_reset_midframe();
        test_back_to_back();
        test_rise_only();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
